// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter
//   Round-robin arbiter sharing one OBI manager port among NumSbrPorts
//   subordinate ports. Granted port indices are queued in an index FIFO so
//   responses return, in order, to the port that issued each request.
//   Request and response paths are purely combinational.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   sbr_ports_req_i   requests from the requesters (one per port)
//   sbr_ports_rsp_o   gnt / rvalid / r back to the requesters
//   mgr_port_req_o    arbitrated request towards the shared port
//   mgr_port_rsp_i    response from the shared port
//   sel_idx_o         current winner, meaningful while mgr_port_req_o.req=1
//   outstanding_o     index-FIFO occupancy (granted, not yet responded)

package obi_pkg;
  typedef struct packed {
    logic UseRReady;
    logic Integrity;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0, Integrity: 1'b0};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_a_t;

  typedef struct packed {
    logic   req;
    obi_a_t a;
    logic   rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } obi_rsp_t;
endpackage

// Per-port response slice: grant only to the winner, response only to the
// port at the head of the index FIFO; everything else reads as zero.
module obi_rr_arbiter_port #(
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t
) (
  input  logic     is_win,
  input  logic     is_head,
  input  logic     fifo_full,
  input  obi_rsp_t mgr_rsp,
  output obi_rsp_t sbr_rsp
);
  always_comb begin
    sbr_rsp     = '0;
    sbr_rsp.gnt = is_win & mgr_rsp.gnt & ~fifo_full;
    if (is_head) begin
      sbr_rsp.rvalid = mgr_rsp.rvalid;
      sbr_rsp.r      = mgr_rsp.r;
    end
  end
endmodule

module obi_rr_arbiter #(
  parameter obi_pkg::obi_cfg_t ObiCfg      = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t   = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t   = obi_pkg::obi_rsp_t,
  parameter int unsigned       NumSbrPorts = 2,
  parameter int unsigned       NumMaxTrans = 2,
  parameter type               idx_t       = logic [$clog2(NumSbrPorts)-1:0]
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t sbr_ports_req_i [NumSbrPorts],
  output obi_rsp_t sbr_ports_rsp_o [NumSbrPorts],
  output obi_req_t mgr_port_req_o,
  input  obi_rsp_t mgr_port_rsp_i,
  output idx_t     sel_idx_o,
  output logic [$clog2(NumMaxTrans+1)-1:0] outstanding_o
);
  localparam int unsigned CntW = $clog2(NumMaxTrans + 1);
  localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;

  if (ObiCfg.Integrity) begin : gen_integrity_unsupported
    $fatal(1, "obi_rr_arbiter: Integrity is not implemented");
  end
  if (NumSbrPorts < 2) begin : gen_bad_ports
    $fatal(1, "obi_rr_arbiter: NumSbrPorts must be >= 2");
  end
  if (NumMaxTrans < 1) begin : gen_bad_trans
    $fatal(1, "obi_rr_arbiter: NumMaxTrans must be >= 1");
  end

  idx_t                        rr_q, lock_idx_q;
  logic                        lock_q;
  idx_t [NumMaxTrans-1:0]      fifo_q;
  logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             cnt_q;

  idx_t scan_idx, cand, win_idx, head_idx;
  logic scan_hit, win_req, fifo_full, fifo_empty, push, pop, rready_eff;

  // Scan from the priority pointer; with nobody requesting, rr_q is reported.
  always_comb begin
    scan_idx = rr_q;
    scan_hit = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NumSbrPorts; k++) begin
      cand = idx_t'((32'(rr_q) + k) % NumSbrPorts);
      if (!scan_hit && sbr_ports_req_i[cand].req) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  assign win_idx    = lock_q ? lock_idx_q : scan_idx;
  assign win_req    = sbr_ports_req_i[win_idx].req;
  assign fifo_full  = (cnt_q == CntW'(NumMaxTrans));
  assign fifo_empty = (cnt_q == '0);
  assign head_idx   = fifo_q[rd_ptr_q];
  assign sel_idx_o     = win_idx;
  assign outstanding_o = cnt_q;

  // Full blocks forwarding even when a pop happens in the same cycle, so
  // there is no path from the response handshake into gnt.
  always_comb begin
    mgr_port_req_o     = '0;
    mgr_port_req_o.req = win_req & ~fifo_full;
    if (win_req) mgr_port_req_o.a = sbr_ports_req_i[win_idx].a;
    mgr_port_req_o.rready = fifo_empty ? 1'b1 : sbr_ports_req_i[head_idx].rready;
  end

  assign rready_eff = ObiCfg.UseRReady ? sbr_ports_req_i[head_idx].rready : 1'b1;
  assign push = mgr_port_req_o.req & mgr_port_rsp_i.gnt;
  // A response with nothing outstanding is dropped (no head to route to).
  assign pop  = mgr_port_rsp_i.rvalid & rready_eff & ~fifo_empty;

  for (genvar i = 0; i < NumSbrPorts; i++) begin : gen_port
    obi_rr_arbiter_port #(.obi_rsp_t(obi_rsp_t)) u_port (
      .is_win   (win_idx == idx_t'(i)),
      .is_head  (!fifo_empty && (head_idx == idx_t'(i))),
      .fifo_full(fifo_full),
      .mgr_rsp  (mgr_port_rsp_i),
      .sbr_rsp  (sbr_ports_rsp_o[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      // Hold the winner whenever it requests but is not granted (gnt low or
      // FIFO full) so req/a stay stable until the handshake.
      lock_q     <= win_req & ~push;
      lock_idx_q <= win_idx;
      if (push) begin
        rr_q <= (win_idx == idx_t'(NumSbrPorts - 1)) ? '0 : win_idx + 1'b1;
        fifo_q[wr_ptr_q] <= win_idx;
        wr_ptr_q <= (wr_ptr_q == PtrW'(NumMaxTrans - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PtrW'(NumMaxTrans - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  a_rvalid_no_outstanding : assert property (@(posedge clk_i) disable iff (!rst_ni)
    mgr_port_rsp_i.rvalid |-> !fifo_empty)
    else $error("obi_rr_arbiter: rvalid with no outstanding transaction");

  a_locked_withdrawn : assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> sbr_ports_req_i[lock_idx_q].req)
    else $error("obi_rr_arbiter: locked requester dropped req before gnt");
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Testbench for obi_rr_arbiter: 4 ports, 2-deep index FIFO, rready honoured.
// Per-port requesters hold req until gnt; an in-order memory model answers
// with a per-port latency. Expected grants/responses are queued by the
// directed stimulus and popped by an independent monitor.
module tb_obi_rr_arbiter;
  import obi_pkg::*;

  localparam int NP = 4;
  localparam int NT = 2;
  localparam obi_cfg_t Cfg = '{UseRReady: 1'b1, Integrity: 1'b0};
  localparam logic [31:0] K = 32'h5A5A_5A5A;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  obi_req_t   sbr_req [NP] = '{default: '0};
  obi_rsp_t   sbr_rsp [NP];
  obi_req_t   mgr_req;
  obi_rsp_t   mgr_rsp;
  logic [1:0] sel_idx;
  logic [1:0] outstanding;

  obi_rr_arbiter #(
    .ObiCfg(Cfg), .obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t),
    .NumSbrPorts(NP), .NumMaxTrans(NT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .sbr_ports_req_i(sbr_req), .sbr_ports_rsp_o(sbr_rsp),
    .mgr_port_req_o(mgr_req), .mgr_port_rsp_i(mgr_rsp),
    .sel_idx_o(sel_idx), .outstanding_o(outstanding)
  );

  typedef struct {int port; logic [31:0] data;} exp_t;
  typedef struct {logic [31:0] addr; int rdy;} mem_t;

  logic [31:0] req_q [NP][$];
  logic        rready_tab [NP];
  int          lat_tab [NP];
  logic        mem_gnt, mem_hold, mem_rvalid;
  logic [31:0] mem_rdata;
  int          exp_gnt [$];
  exp_t        exp_rsp [$];
  int          checks = 0;
  int          errors = 0;
  logic [NP-1:0] gv, rv;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      gv[p] = sbr_rsp[p].gnt;
      rv[p] = sbr_rsp[p].rvalid;
    end
  end

  always_comb begin
    mgr_rsp         = '0;
    mgr_rsp.gnt     = mem_gnt;
    mgr_rsp.rvalid  = mem_rvalid;
    mgr_rsp.r.rdata = mem_rdata;
  end

  // Requesters: keep req/a until the handshake, then move to the next entry.
  logic [NP-1:0] drv_hs;
  always @(posedge clk_i) begin
    for (int p = 0; p < NP; p++) drv_hs[p] = rst_ni && sbr_req[p].req && sbr_rsp[p].gnt;
    #1;
    for (int p = 0; p < NP; p++) begin
      if (drv_hs[p] && req_q[p].size() > 0) void'(req_q[p].pop_front());
      sbr_req[p] = '0;
      sbr_req[p].rready = rready_tab[p];
      if (req_q[p].size() > 0) begin
        sbr_req[p].req    = 1'b1;
        sbr_req[p].a.addr = req_q[p][0];
        sbr_req[p].a.be   = 4'hf;
      end
    end
  end

  // In-order memory: rvalid no earlier than lat cycles after the gnt cycle.
  mem_t mq [$];
  int   mem_cyc = 0;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_cyc = mem_cyc + 1;
      if (mem_rvalid && mgr_req.rready && mq.size() > 0) void'(mq.pop_front());
      if (mgr_req.req && mgr_rsp.gnt) mq.push_back('{mgr_req.a.addr, mem_cyc + lat_tab[sel_idx] - 1});
      if (mq.size() > 0 && mq[0].rdy <= mem_cyc && !mem_hold) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mq[0].addr ^ K;
      end else begin
        mem_rvalid <= 1'b0;
        mem_rdata  <= '0;
      end
    end
  end

  // Monitor: grants and response handshakes against the scoreboard queues.
  int   ng, nr, eg;
  exp_t er;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      ng = 0;
      for (int p = 0; p < NP; p++) begin
        if (sbr_req[p].req && sbr_rsp[p].gnt) begin
          ng++;
          checks++;
          if (exp_gnt.size() == 0) begin
            errors++;
            $display("FAIL gnt_order: unexpected grant to port %0d", p);
          end else begin
            eg = exp_gnt.pop_front();
            if (eg != p) begin
              errors++;
              $display("FAIL gnt_order: granted port %0d, required port %0d", p, eg);
            end
          end
        end
      end
      if (ng > 0) begin
        checks++;
        if (ng != 1) begin errors++; $display("FAIL gnt_onehot: %0d grants, required 1", ng); end
      end
      nr = $countones(rv);
      if (nr > 0 || mgr_rsp.rvalid) begin
        checks++;
        if (nr != 1 || !mgr_rsp.rvalid) begin
          errors++;
          $display("FAIL rvalid_route: sbr rvalid=%b mgr rvalid=%b, required exactly one", rv, mgr_rsp.rvalid);
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (sbr_rsp[p].rvalid && sbr_req[p].rready) begin
          checks++;
          if (exp_rsp.size() == 0) begin
            errors++;
            $display("FAIL rsp_order: unexpected response on port %0d", p);
          end else begin
            er = exp_rsp.pop_front();
            if (er.port != p || er.data != sbr_rsp[p].r.rdata) begin
              errors++;
              $display("FAIL rsp_order: port %0d data %h, required port %0d data %h",
                       p, sbr_rsp[p].r.rdata, er.port, er.data);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #2;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic issue(input int p, input logic [31:0] a);
    req_q[p].push_back(a);
  endtask

  task automatic expect_tr(input int p, input logic [31:0] a, input bit with_rsp);
    exp_gnt.push_back(p);
    if (with_rsp) exp_rsp.push_back('{p, a ^ K});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_gnt.size() != 0) && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain_timeout: %0d grants, %0d responses still pending", exp_gnt.size(), exp_rsp.size());
    end
  endtask

  initial begin
    mem_gnt  = 1'b0;
    mem_hold = 1'b0;
    for (int p = 0; p < NP; p++) begin
      rready_tab[p] = 1'b1;
      lat_tab[p]    = 1;
    end
    repeat (2) sample();
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_sel_idx", 32'(sel_idx), 0);
    chk("rst_mgr_req", 32'(mgr_req.req), 0);
    chk("rst_gnt", 32'(gv), 0);
    chk("rst_rvalid", 32'(rv), 0);
    step();
    rst_ni = 1'b1;

    // All four ports at once (port 0 twice): 0,1,2,3,0
    mem_gnt = 1'b1;
    issue(0, 32'h0000_1000); issue(1, 32'h0000_2004); issue(2, 32'h0000_3008);
    issue(3, 32'h0000_400C); issue(0, 32'h0000_1010);
    expect_tr(0, 32'h0000_1000, 1); expect_tr(1, 32'h0000_2004, 1);
    expect_tr(2, 32'h0000_3008, 1); expect_tr(3, 32'h0000_400C, 1);
    expect_tr(0, 32'h0000_1010, 1);
    drain();

    // Move the pointer to 0, then stall port 2 and let port 0 arrive.
    issue(3, 32'h0000_4100); expect_tr(3, 32'h0000_4100, 1);
    drain();
    mem_gnt = 1'b0;
    issue(2, 32'h0000_3200);
    expect_tr(2, 32'h0000_3200, 1); expect_tr(0, 32'h0000_1200, 1);
    for (int k = 0; k < 3; k++) begin
      step(); sample();
      chk("lock_sel_idx", 32'(sel_idx), 2);
      chk("lock_mgr_req", 32'(mgr_req.req), 1);
    end
    issue(0, 32'h0000_1200);
    step(); sample();
    chk("lock_hold_sel", 32'(sel_idx), 2);
    chk("lock_no_gnt", 32'(gv), 0);
    step();
    mem_gnt = 1'b1;
    drain();

    // FIFO full: two grants, memory silent, third requester blocked.
    mem_hold = 1'b1;
    issue(1, 32'h0000_2300); issue(2, 32'h0000_3300); issue(3, 32'h0000_4300);
    expect_tr(1, 32'h0000_2300, 1); expect_tr(2, 32'h0000_3300, 1); expect_tr(3, 32'h0000_4300, 1);
    step(); step(); step(); sample();
    chk("full_mgr_req", 32'(mgr_req.req), 0);
    chk("full_outstanding", 32'(outstanding), 2);
    step();
    mem_hold = 1'b0;
    sample();
    chk("full_mgr_req_hold", 32'(mgr_req.req), 0);
    step(); sample();
    chk("full_pop_rvalid", 32'(rv), 32'b0010);
    chk("full_blocks_on_pop", 32'(mgr_req.req), 0);
    chk("full_outstanding_pop", 32'(outstanding), 2);
    step(); sample();
    chk("full_regrant_req", 32'(mgr_req.req), 1);
    chk("full_regrant_sel", 32'(sel_idx), 3);
    chk("full_outstanding_after", 32'(outstanding), 1);
    step(); sample();
    chk("push_pop_outstanding", 32'(outstanding), 1);
    drain();

    // Slow port 1 then fast port 3: responses stay in grant order.
    lat_tab[1] = 5;
    issue(1, 32'h0000_2400); issue(3, 32'h0000_4400);
    expect_tr(1, 32'h0000_2400, 1); expect_tr(3, 32'h0000_4400, 1);
    drain();
    lat_tab[1] = 1;

    // rready backpressure on the head port for two cycles.
    rready_tab[2] = 1'b0;
    issue(2, 32'h0000_3500); expect_tr(2, 32'h0000_3500, 1);
    step();
    for (int k = 0; k < 2; k++) begin
      step(); sample();
      chk("bp_rvalid", 32'(rv), 32'b0100);
      chk("bp_mgr_rready", 32'(mgr_req.rready), 0);
      chk("bp_outstanding", 32'(outstanding), 1);
      chk("bp_rdata", sbr_rsp[2].r.rdata, 32'h0000_3500 ^ K);
    end
    rready_tab[2] = 1'b1;
    drain();

    // Reset with two transactions outstanding.
    mem_hold = 1'b1;
    issue(0, 32'h0000_1600); issue(1, 32'h0000_2600);
    expect_tr(0, 32'h0000_1600, 0); expect_tr(1, 32'h0000_2600, 0);
    step(); step(); step(); sample();
    chk("mid_outstanding_pre", 32'(outstanding), 2);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_outstanding", 32'(outstanding), 0);
    chk("mid_rst_rvalid", 32'(rv), 0);
    chk("mid_rst_sel", 32'(sel_idx), 0);
    step(); step();
    rst_ni   = 1'b1;
    mem_hold = 1'b0;
    issue(1, 32'h0000_2700); issue(3, 32'h0000_4700);
    expect_tr(1, 32'h0000_2700, 1); expect_tr(3, 32'h0000_4700, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/obi_rr_arbiter.md
# obi_rr_arbiter

Round-robin arbiter that shares one OBI manager port (towards a crossbar, `obi_demux` or a memory) among `NumSbrPorts` requesting subordinate ports. It keeps a FIFO of granted port indices so that responses are returned in order to the port that issued them. The request and response paths are combinational, with no added latency. It sits at the front of a shared bus segment, for example where several cores share one memory or demux.

## Interface
- `ObiCfg`, `obi_pkg::ObiDefaultConfig`, OBI configuration for all ports. `Integrity=1` is a `$fatal` (unimplemented).
- `obi_req_t`, `logic`, request struct for all ports.
- `obi_rsp_t`, `logic`, response struct for all ports.
- `NumSbrPorts`, `2`, number of requesting ports. Must be ≥2.
- `NumMaxTrans`, `2`, maximum number of outstanding transactions. This is the index-FIFO depth. Must be ≥1.
- `idx_t`, `logic [$clog2(NumSbrPorts)-1:0]`, port index type.

Ports:
- `clk_i`  in  1  clock. Single clock domain.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `sbr_ports_req_i`  in  `obi_req_t [NumSbrPorts]`  requests from the requesters.
- `sbr_ports_rsp_o`  out  `obi_rsp_t [NumSbrPorts]`  gnt/rvalid/r back to the requesters.
- `mgr_port_req_o`  out  `obi_req_t`  arbitrated request to the shared port.
- `mgr_port_rsp_i`  in  `obi_rsp_t`  response from the shared port.
- `sel_idx_o`  out  `idx_t`  current arbitration winner. Valid when `mgr_port_req_o.req`=1.
- `outstanding_o`  out  `$clog2(NumMaxTrans+1)`  occupancy of the index FIFO.

## Operation
- **State:**
  - `rr_q`: priority pointer, type `idx_t`.
  - `lock_q` and `lock_idx_q`: winner held while a request is pending.
  - Index FIFO: depth `NumMaxTrans`, entries of type `idx_t`.
- **Winner selection:**
  - If `lock_q`=1, winner = `lock_idx_q`.
  - Otherwise, winner = the first `i` with `req`=1, scanning `rr_q`, `rr_q+1`, … modulo `NumSbrPorts`.
- **Forwarding:**
  - `mgr.req` = winner.req && !fifo_full.
  - `mgr.a` = winner.a. `a` is `'0` when no port requests.
  - winner.gnt = `mgr.gnt` && !fifo_full. All other ports get gnt=0.
- **Handshake** (`mgr.req` && `mgr.gnt`):
  - Push the winner index into the FIFO.
  - `rr_q` ← winner+1, wrapping from `NumSbrPorts-1` to 0.
  - `lock_q` ← 0.
- **Lock:** if `mgr.req`=1 and `gnt`=0, set `lock_q` ← 1 and `lock_idx_q` ← winner. This keeps req/a stable until gnt, as OBI requires. It also holds when the stall is caused by a full FIFO and the winner keeps requesting.
- **Response routing:** `head` = FIFO head index.
  - `sbr[head].rvalid` = `mgr.rvalid`.
  - `sbr[head].r` = `mgr.r`.
  - All other ports: rvalid=0, r=`'0`.
- **Pop** on `mgr.rvalid` && rready_eff.
  - rready_eff = `sbr[head].rready` if `ObiCfg.UseRReady`, else 1.
  - `mgr.rready` = `sbr[head].rready` when the FIFO is non-empty, else 1.
- **Full FIFO:** blocks forwarding even if a pop occurs in the same cycle. This is deliberate: it avoids a gnt→pop combinational path.
- **Push and pop in the same cycle** (not full): occupancy is unchanged.
- **Protocol violation:** `mgr.rvalid` with the FIFO empty is an assertion error. The response is dropped and no port sees rvalid.
- **Request withdrawal:** a locked requester that drops req before gnt is an assertion error (OBI violation).

## Timing
- **Reset values:**
  - `rr_q`=0, `lock_q`=0, FIFO empty.
  - `outstanding_o`=0, `sel_idx_o`=0.
  - `mgr_port_req_o.req`=0 and all `gnt`=0, given idle inputs.
  - All `rvalid`=0.
- **Latency:** the request path is combinational, 0 cycles. The response path is combinational, 0 cycles.
- **Pointer and FIFO updates:** `rr_q`, lock state and the FIFO update on the clock edge after the handshake.
- **Earliest response:** rvalid in the cycle after gnt (OBI). The arbiter also tolerates the OBI minimum of one cycle.
- **Back-to-back grants:** one per cycle while the FIFO is not full. Sustained throughput is 1 transaction/cycle when `NumMaxTrans`≥2 and the response arrives one cycle after gnt.
- **Reset mid-operation:** the FIFO is cleared and outstanding responses are lost. This is the system's responsibility.

## Test plan
- **Simultaneous requests, reset state.** All 4 ports request (NumSbrPorts=4), memory with gnt=1 and 1-cycle rvalid. Required: grants in order 0,1,2,3,0. Each port receives its own rdata, tagged by address.
- **Lock on stall.** Port 2 requests alone and gnt=0 for 3 cycles, then port 0 requests. Required: port 2 stays the winner and is granted when gnt rises. Port 0 is granted next.
- **FIFO full.** NumMaxTrans=2, 2 grants issued, memory holds rvalid low. Required: `mgr.req`=0 and `outstanding_o`=2. After one rvalid, the next grant happens one cycle later.
- **Out-of-order latency.** Port 1's access takes 5 cycles and port 3's takes 1 cycle (memory in-order queue). Required: responses go to port 1 then port 3, and no rvalid appears on other ports.
- **rready backpressure** (UseRReady=1). The head port holds rready=0 for 2 cycles. Required: `mgr.rready`=0, the FIFO does not pop, and rdata is stable until the handshake.
- **Mid-stream reset.** Assert `rst_ni` with 2 transactions outstanding. Required: immediate `outstanding_o`=0, all rvalid=0, and `rr_q`=0 after release.
